// File: rtl/path_delay_monitor.sv
// ============================================================================
//  path_delay_monitor
//  Launch/capture controller that measures whether a spy path settles in time.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module path_delay_monitor #(
  parameter int NUM_TRIALS = 16,
  parameter int CNT_W      = 8,
  parameter bit INVERT     = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       settle,
  output logic             launch_out,
  input  logic             path_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] rise_err,
  output logic [CNT_W-1:0] fall_err,
  output logic [7:0]       first_err
);

  localparam int TW = (NUM_TRIALS > 2) ? $clog2(NUM_TRIALS) : 1;

  localparam logic [2:0] c_idle    = 3'd0;
  localparam logic [2:0] c_launch  = 3'd1;
  localparam logic [2:0] c_wait    = 3'd2;
  localparam logic [2:0] c_capture = 3'd3;
  localparam logic [2:0] c_done    = 3'd4;

  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [TW-1:0]    c_last     = TW'(NUM_TRIALS - 1);
  localparam logic [TW-1:0]    c_trial_one = TW'(1);
  localparam logic [7:0]       c_no_err   = 8'hFF;

  logic [2:0]       state_q, state_d;
  logic             launch_q, launch_d;
  logic [7:0]       settle_q, settle_d;
  logic [8:0]       wait_q, wait_d;
  logic [TW-1:0]    trial_q, trial_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] rise_q, rise_d;
  logic [CNT_W-1:0] fall_q, fall_d;
  logic [7:0]       first_q, first_d;
  logic             sync1_q, sync2_q;

  logic             w_mismatch;

  assign w_mismatch = (sync2_q != (launch_q ^ INVERT));

  always_comb begin
    state_d  = state_q;
    launch_d = launch_q;
    settle_d = settle_q;
    wait_d   = wait_q;
    trial_d  = trial_q;
    err_d    = err_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    first_d  = first_q;
    case (state_q)
      c_idle: begin
        if (start) begin
          settle_d = (settle == 8'd0) ? 8'd1 : settle;
          trial_d  = '0;
          err_d    = '0;
          rise_d   = '0;
          fall_d   = '0;
          first_d  = c_no_err;
          state_d  = c_launch;
        end
      end
      c_launch: begin
        launch_d = ~launch_q;
        // Two extra cycles absorb the input synchronizer latency.
        wait_d   = {1'b0, settle_q} + 9'd2;
        state_d  = c_wait;
      end
      c_wait: begin
        wait_d = wait_q - 9'd1;
        if (wait_q == 9'd1) begin
          state_d = c_capture;
        end
      end
      c_capture: begin
        if (w_mismatch) begin
          if (err_q != c_cnt_max) err_d = err_q + c_cnt_one;
          if (launch_q) begin
            if (rise_q != c_cnt_max) rise_d = rise_q + c_cnt_one;
          end else begin
            if (fall_q != c_cnt_max) fall_d = fall_q + c_cnt_one;
          end
          if (first_q == c_no_err) first_d = 8'(trial_q);
        end
        trial_d = trial_q + c_trial_one;
        state_d = (trial_q == c_last) ? c_done : c_launch;
      end
      c_done: begin
        state_d = c_idle;
      end
      default: begin
        state_d = c_idle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= c_idle;
      launch_q <= 1'b0;
      settle_q <= 8'd1;
      wait_q   <= '0;
      trial_q  <= '0;
      err_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      first_q  <= c_no_err;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      launch_q <= launch_d;
      settle_q <= settle_d;
      wait_q   <= wait_d;
      trial_q  <= trial_d;
      err_q    <= err_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      first_q  <= first_d;
      sync1_q  <= path_in;
      sync2_q  <= sync1_q;
    end
  end

  assign launch_out = launch_q;
  assign busy       = (state_q != c_idle);
  assign done       = (state_q == c_done);
  assign err_cnt    = err_q;
  assign rise_err   = rise_q;
  assign fall_err   = fall_q;
  assign first_err  = first_q;

endmodule

`default_nettype wire
